// File: rtl/int_issue_queue.sv
// Integer ALU issue queue: collapsing, oldest-first select, CDB wakeup on stored and incoming entries.
// Entry 0 is the oldest; occupied entries stay packed from index 0.
module int_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dpch_alu_en,
    input  logic [31:0]      dpch_op1_data,
    input  logic [TAG_W-1:0] dpch_op1_tag,
    input  logic             dpch_op1_data_valid,
    input  logic [31:0]      dpch_op2_data,
    input  logic [TAG_W-1:0] dpch_op2_tag,
    input  logic             dpch_op2_data_valid,
    input  logic [TAG_W-1:0] dpch_rd_tag,
    input  logic             dpch_rd_tag_valid,
    input  logic [2:0]       dpch_funct3,
    input  logic [2:0]       dpch_alu_ext,
    output logic             iq_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [31:0]      issue_op1,
    output logic [31:0]      issue_op2,
    output logic [TAG_W-1:0] issue_rd_tag,
    output logic             issue_rd_tag_valid,
    output logic [2:0]       issue_funct3,
    output logic [2:0]       issue_alu_ext
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             occ;
        logic [31:0]      op1;
        logic [TAG_W-1:0] t1;
        logic             v1;
        logic [31:0]      op2;
        logic [TAG_W-1:0] t2;
        logic             v2;
        logic [TAG_W-1:0] rd_tag;
        logic             rd_v;
        logic [2:0]       funct3;
        logic [2:0]       alu_ext;
    } ent_t;

    ent_t             ent     [DEPTH];
    ent_t             ent_up  [DEPTH];
    ent_t             ent_nxt [DEPTH];
    ent_t             new_ent;
    logic [CNT_W-1:0] cnt, cnt_nxt, wr_pos;
    logic [DEPTH-1:0] rdy, shift;
    logic [IDX_W-1:0] sel;
    logic             fire, wr, found;

    // Tags are only compared while the operand is still pending.
    function automatic ent_t wake(ent_t e, logic cv, logic [TAG_W-1:0] ct, logic [31:0] cd);
        ent_t r;
        r = e;
        if (cv && e.occ && !e.v1 && e.t1 == ct) begin
            r.op1 = cd;
            r.v1  = 1'b1;
        end
        if (cv && e.occ && !e.v2 && e.t2 == ct) begin
            r.op2 = cd;
            r.v2  = 1'b1;
        end
        return r;
    endfunction

    // shift[i] marks the selected entry and everything above it.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        shift = '0;
        rdy   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = ent[i].occ & ent[i].v1 & ent[i].v2;
            if (!found && rdy[i]) sel = IDX_W'(i);
            found    = found | rdy[i];
            shift[i] = found;
        end
    end

    assign issue_valid = |rdy;
    assign fire        = issue_valid & issue_ready;
    assign iq_full     = (cnt == CNT_W'(DEPTH));
    assign wr          = dpch_alu_en & ~iq_full;
    assign wr_pos      = fire ? cnt - 1'b1 : cnt;
    assign cnt_nxt     = cnt + CNT_W'(wr) - CNT_W'(fire);

    always_comb begin
        new_ent         = '0;
        new_ent.occ     = 1'b1;
        new_ent.op1     = dpch_op1_data;
        new_ent.t1      = dpch_op1_tag;
        new_ent.v1      = dpch_op1_data_valid;
        new_ent.op2     = dpch_op2_data;
        new_ent.t2      = dpch_op2_tag;
        new_ent.v2      = dpch_op2_data_valid;
        new_ent.rd_tag  = dpch_rd_tag;
        new_ent.rd_v    = dpch_rd_tag_valid;
        new_ent.funct3  = dpch_funct3;
        new_ent.alu_ext = dpch_alu_ext;
    end

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) ent_up[i] = ent[i+1];
        ent_up[DEPTH-1] = '0;
    end

    always_comb begin
        ent_t tmp;
        for (int i = 0; i < DEPTH; i++) begin
            tmp = (fire && shift[i]) ? ent_up[i] : ent[i];
            if (wr && wr_pos == CNT_W'(i)) tmp = new_ent;
            ent_nxt[i] = wake(tmp, cdb_valid, cdb_tag, cdb_data);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            cnt <= cnt_nxt;
            for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
        end
    end

    assign issue_op1          = issue_valid ? ent[sel].op1     : '0;
    assign issue_op2          = issue_valid ? ent[sel].op2     : '0;
    assign issue_rd_tag       = issue_valid ? ent[sel].rd_tag  : '0;
    assign issue_rd_tag_valid = issue_valid ? ent[sel].rd_v    : 1'b0;
    assign issue_funct3       = issue_valid ? ent[sel].funct3  : '0;
    assign issue_alu_ext      = issue_valid ? ent[sel].alu_ext : '0;
endmodule
